ampersan_jump: RTL and testbench
================================

# ampersan_jump

Jump-target formation unit for the single-cycle MIPS datapath. Concatenates the upper nibble of PC+4 with the 26-bit J-type immediate and two zero bits to produce the 32-bit absolute jump target. The target feeds the PC-source mux ahead of the PC register. Also provides a valid-qualified output stage and a saturating jump-event counter for the performance block.

## Interface

- Clocking: one clock; reset is asynchronous and active-high.
- No parameters. Widths are fixed by the ISA.
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `pc_inc`  input  4  bits [31:28] of PC+4.
- `jump_address`  input  26  J-type instruction field, instr[25:0].
- `in_valid`  input  1  marks a jump instruction this cycle.
- `clr_count`  input  1  synchronous clear of `jump_count`.
- `pc_jump`  output  32  jump target. Combinational or registered depending on Configuration.
- `out_valid`  output  1  qualifies `pc_jump`.
- `jump_count`  output  16  number of accepted jumps, saturating.

## Operation

- Target formula: `pc_jump = {pc_inc[3:0], jump_address[25:0], 2'b00}`.
  - Bits [1:0] are always 0, so the target is word-aligned.
  - No carry or sign extension. Pure bit placement.
- `out_valid` follows `in_valid` with the same latency as `pc_jump`.
- `pc_jump` is computed regardless of `in_valid`. Consumers must qualify it with `out_valid`.
- Counter rules for `jump_count`:
  - On each rising edge with `in_valid=1`, increment by 1.
  - Saturate at 16'hFFFF. It never wraps.
  - `clr_count=1` sets it to 0 on the next edge. Clear has priority over increment when both are active in the same cycle.
- Reset clears all state: the registered target, `out_valid` and `jump_count` all go to 0, immediately and independent of `clk`.
- Reset asserted mid-operation discards any pending registered target. The first valid output after reset release is the first sample taken after release.

## Timing

- Combinational build: `pc_jump` and `out_valid` settle within the same cycle as the inputs. Latency is 0 cycles.
- Registered build: inputs are sampled on a rising `clk` edge and appear after that edge. Latency is 1 cycle.
- `jump_count` always updates on the rising edge, so it reflects accepted jumps 1 cycle later.
- Reset values:
  - `out_valid = 0`, `jump_count = 0`.
  - Registered `pc_jump = 32'h0000_0000`.
  - Combinational `pc_jump` tracks its inputs even during reset.
- No handshake back-pressure. Every `in_valid` cycle is accepted.

## Configuration

- Macro: `AMPERSAN_REG_OUT_EN`.
- Defined:
  - `pc_jump` and `out_valid` come from flops clocked by `clk` and cleared by `reset`.
  - One-cycle latency.
- Undefined:
  - `pc_jump` and `out_valid` are purely combinational from `pc_inc`, `jump_address` and `in_valid`.
  - Zero latency. This is the single-cycle datapath default.
- `jump_count` is present and identical in both builds.

## Test plan

- `pc_inc=4'b0000`, `jump_address=26'h0`, `in_valid=1` -> `pc_jump=32'h0000_0000`, `out_valid=1`.
- `pc_inc=4'b1111`, `jump_address=26'b1011` -> `pc_jump=32'hF000_002C`. Applies after 1 edge in the registered build.
- `pc_inc=4'b1000`, `jump_address=26'h1FF` -> `pc_jump=32'h8000_07FC`.
- `pc_inc=4'hF`, `jump_address=26'h3FF_FFFF` -> `pc_jump=32'hFFFF_FFFC`. Bits [1:0] stay 0.
- Counter scenario:
  - Hold `in_valid=1` for 70000 cycles -> `jump_count` stops at 16'hFFFF.
  - Then `clr_count=1` with `in_valid=1` for one cycle -> `jump_count=0`.
- Assert `reset` asynchronously between edges with `out_valid=1` and `jump_count=5`:
  - `out_valid` and `jump_count` go to 0 immediately.
  - Registered `pc_jump` reads 0 until the first edge after release.

Source files
------------

// File: rtl/ampersan_jump.sv
// Jump-target formation for the single-cycle MIPS datapath plus a saturating jump counter.
// Define AMPERSAN_REG_OUT_EN to register pc_jump/out_valid (1-cycle latency); default is combinational.
module ampersan_jump (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  pc_inc,
   input  logic [25:0] jump_address,
   input  logic        in_valid,
   input  logic        clr_count,
   output logic [31:0] pc_jump,
   output logic        out_valid,
   output logic [15:0] jump_count
);

   localparam int unsigned TGT_W = 32;
   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [TGT_W-1:0] target_c;

   // Pure bit placement: upper nibble of PC+4, word index, word alignment.
   assign target_c = {pc_inc, jump_address, 2'b00};

`ifdef AMPERSAN_REG_OUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_jump   <= '0;
         out_valid <= 1'b0;
      end else begin
         pc_jump   <= target_c;
         out_valid <= in_valid;
      end
   end
`else
   // Target tracks inputs even in reset; only the qualifier is held low.
   assign pc_jump   = target_c;
   assign out_valid = in_valid & ~reset;
`endif

   // Clear wins over increment; count holds at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         jump_count <= '0;
      end else if (clr_count) begin
         jump_count <= '0;
      end else if (in_valid && (jump_count != CNT_MAX)) begin
         jump_count <= jump_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ampersan_jump.sv
// Directed self-checking bench for ampersan_jump; follows AMPERSAN_REG_OUT_EN when defined.
module tb_ampersan_jump;

   logic        clk;
   logic        reset;
   logic [3:0]  pc_inc;
   logic [25:0] jump_address;
   logic        in_valid;
   logic        clr_count;
   logic [31:0] pc_jump;
   logic        out_valid;
   logic [15:0] jump_count;

   int n_checks;
   int n_fail;
   int exp_count;

`ifdef AMPERSAN_REG_OUT_EN
   localparam bit REG_BUILD = 1'b1;
`else
   localparam bit REG_BUILD = 1'b0;
`endif

   ampersan_jump dut (
      .clk          (clk),
      .reset        (reset),
      .pc_inc       (pc_inc),
      .jump_address (jump_address),
      .in_valid     (in_valid),
      .clr_count    (clr_count),
      .pc_jump      (pc_jump),
      .out_valid    (out_valid),
      .jump_count   (jump_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Apply one vector, cross one edge, then check target, qualifier and count.
   task automatic run_vec(input string tag, input logic [3:0] pi, input logic [25:0] ja,
                          input logic v, input logic [31:0] exp_tgt);
      pc_inc       = pi;
      jump_address = ja;
      in_valid     = v;
      if (!REG_BUILD) begin
         #1;
         check({tag, "_comb_tgt"}, pc_jump, exp_tgt);
         check({tag, "_comb_vld"}, 32'(out_valid), 32'(v));
      end
      @(posedge clk);
      #1;
      if (v) exp_count++;
      check({tag, "_tgt"}, pc_jump, exp_tgt);
      check({tag, "_vld"}, 32'(out_valid), 32'(v));
      check({tag, "_cnt"}, 32'(jump_count), 32'(exp_count));
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      exp_count    = 0;
      reset        = 1'b1;
      pc_inc       = 4'h0;
      jump_address = 26'h0;
      in_valid     = 1'b0;
      clr_count    = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_vld", 32'(out_valid), 32'h0);
      check("rst_cnt", 32'(jump_count), 32'h0);
      check("rst_tgt0", pc_jump, 32'h0);
      pc_inc       = 4'hF;
      jump_address = 26'h1;
      #1;
      check("rst_tgt_in", pc_jump, REG_BUILD ? 32'h0 : 32'hF000_0004);
      @(posedge clk);
      #1;
      reset = 1'b0;

      run_vec("zero",  4'h0, 26'h0,        1'b1, 32'h0000_0000);
      run_vec("f_b",   4'hF, 26'b1011,     1'b1, 32'hF000_002C);
      run_vec("8_1ff", 4'h8, 26'h1FF,      1'b1, 32'h8000_07FC);
      run_vec("ones",  4'hF, 26'h3FF_FFFF, 1'b1, 32'hFFFF_FFFC);
      run_vec("novld", 4'h5, 26'h2AA_AAAA, 1'b0, 32'h5AAA_AAA8);

      // Saturation: approach 0xFFFF, then hold in_valid well past it.
      in_valid = 1'b1;
      repeat (65534 - exp_count) @(posedge clk);
      #1;
      check("cnt_fffe", 32'(jump_count), 32'h0000_FFFE);
      @(posedge clk);
      #1;
      check("cnt_ffff", 32'(jump_count), 32'h0000_FFFF);
      repeat (4470) @(posedge clk);
      #1;
      check("cnt_sat", 32'(jump_count), 32'h0000_FFFF);

      // Clear beats a simultaneous increment.
      clr_count = 1'b1;
      @(posedge clk);
      #1;
      clr_count = 1'b0;
      check("cnt_clr", 32'(jump_count), 32'h0);

      pc_inc       = 4'h3;
      jump_address = 26'h0_0040;
      repeat (5) @(posedge clk);
      #1;
      check("cnt_5", 32'(jump_count), 32'd5);
      check("vld_pre_rst", 32'(out_valid), 32'h1);

      // Asynchronous reset between edges.
      #2;
      reset = 1'b1;
      #1;
      check("arst_vld", 32'(out_valid), 32'h0);
      check("arst_cnt", 32'(jump_count), 32'h0);
      check("arst_tgt", pc_jump, REG_BUILD ? 32'h0 : 32'h3000_0100);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rel_tgt", pc_jump, REG_BUILD ? 32'h0 : 32'h3000_0100);
      @(posedge clk);
      #1;
      check("post_tgt", pc_jump, 32'h3000_0100);
      check("post_vld", 32'(out_valid), 32'h1);
      check("post_cnt", 32'(jump_count), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
